// File: rtl/ws2812_pkg.sv
// Shared types and default 50 MHz timing for the WS2812 frame driver.
// Imported by the bit timer and by the frame-level top.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int WORD_W       = 24;
  localparam int DEF_NUM_LEDS = 60;
  localparam int DEF_T0H      = 20;
  localparam int DEF_T1H      = 40;
  localparam int DEF_TBIT     = 63;
  localparam int DEF_TRESET   = 3000;

  // MSB wraps to LSB so the same colour word replays for every pixel.
  function automatic logic [WORD_W-1:0] rotl1(input logic [WORD_W-1:0] w);
    return {w[WORD_W-2:0], w[WORD_W-1]};
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// NRZ bit-period generator: one TBIT-long period per bit_start, high for
// T1H or T0H cycles depending on the bit value; dout is registered.
module ws2812_bit_timer #(
  parameter int T0H  = 20,
  parameter int T1H  = 40,
  parameter int TBIT = 63
) (
  input  logic clk,
  input  logic reset_n,
  input  logic bit_start,
  input  logic bit_val,
  output logic dout,
  output logic bit_end
);

  localparam int CW = $clog2(TBIT + 1);

  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic          val_q, val_d;
  logic          act_q, act_d;
  logic          dout_q, dout_d;
  logic          bit_end_s;
  logic [CW-1:0] thr_s;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    val_d     = val_q;
    act_d     = act_q;
    bit_end_s = act_q && (cyc_cnt_q == CW'(TBIT - 1));
    if (bit_start) begin
      cyc_cnt_d = '0;
      val_d     = bit_val;
      act_d     = 1'b1;
    end else if (bit_end_s) begin
      cyc_cnt_d = '0;
      act_d     = 1'b0;
    end else if (act_q) begin
      cyc_cnt_d = cyc_cnt_q + CW'(1);
    end else begin
      cyc_cnt_d = cyc_cnt_q;
    end
    // Output level is decided from the next-cycle counter so the pin is registered.
    thr_s  = val_d ? CW'(T1H) : CW'(T0H);
    dout_d = act_d && (cyc_cnt_d < thr_s);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt_q <= '0;
      val_q     <= 1'b0;
      act_q     <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      val_q     <= val_d;
      act_q     <= act_d;
      dout_q    <= dout_d;
    end
  end

  assign dout    = dout_q;
  assign bit_end = bit_end_s;

endmodule

// File: rtl/ws2812_frame_driver.sv
// Frame sequencer: latches a G/R/B triple on start, sends it to NUM_LEDS
// chained pixels MSB first, then holds the line low for TRESET cycles.
module ws2812_frame_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int TBIT     = DEF_TBIT,
  parameter int TRESET   = DEF_TRESET
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] color_g,
  input  logic [7:0] color_r,
  input  logic [7:0] color_b,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  output logic       led_dout
);

  localparam int PIX_W = $clog2(NUM_LEDS + 1);
  localparam int RST_W = $clog2(TRESET + 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic bit_start_s, bit_val_s, bit_end_s;
  logic last_bit_s, last_pix_s;

  ws2812_bit_timer #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_bit_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .bit_start (bit_start_s),
    .bit_val   (bit_val_s),
    .dout      (led_dout),
    .bit_end   (bit_end_s)
  );

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bit_cnt_d   = bit_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    rst_cnt_d   = rst_cnt_q;
    bit_start_s = 1'b0;
    bit_val_s   = 1'b0;
    last_bit_s  = (bit_cnt_q == 5'd23);
    last_pix_s  = (pix_cnt_q == PIX_W'(NUM_LEDS - 1));
    case (state_q)
      IDLE: begin
        if (start) begin
          word_d      = {color_g, color_r, color_b};
          bit_cnt_d   = 5'd0;
          pix_cnt_d   = '0;
          rst_cnt_d   = '0;
          bit_start_s = 1'b1;
          bit_val_s   = color_g[7];
          state_d     = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (bit_end_s) begin
          word_d    = rotl1(word_q);
          // The bit after the rotation is the current word's second MSB.
          bit_val_s = word_q[WORD_W-2];
          if (last_bit_s) begin
            bit_cnt_d = 5'd0;
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
            if (last_pix_s) begin
              rst_cnt_d = '0;
              state_d   = LATCH;
            end else begin
              bit_start_s = 1'b1;
            end
          end else begin
            bit_cnt_d   = bit_cnt_q + 5'd1;
            bit_start_s = 1'b1;
          end
        end else begin
          state_d = SEND;
        end
      end
      LATCH: begin
        if (rst_cnt_q == RST_W'(TRESET - 1)) begin
          state_d = DONE;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      bit_cnt_q <= 5'd0;
      pix_cnt_q <= '0;
      rst_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      bit_cnt_q <= bit_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      rst_cnt_q <= rst_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Self-checking bench for ws2812_frame_driver with two pixels per frame:
// decodes led_dout pulse widths against a queue of expected bit widths.
module tb_ws2812_frame_driver;

  localparam int NL        = 2;
  localparam int TB        = 63;
  localparam int TR        = 3000;
  localparam int FRAME_OFF = NL * 24 * TB + TR;  // edge of start -> DONE cycle

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] color_g = 8'h00;
  logic [7:0] color_r = 8'h00;
  logic [7:0] color_b = 8'h00;
  logic       start = 1'b0;
  logic       busy, frame_done, led_dout;

  ws2812_frame_driver #(
    .NUM_LEDS (NL),
    .T0H      (20),
    .T1H      (40),
    .TBIT     (TB),
    .TRESET   (TR)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .color_g    (color_g),
    .color_r    (color_r),
    .color_b    (color_b),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .led_dout   (led_dout)
  );

  always #5 clk = ~clk;

  int cnt = 0;
  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int ones = 0;
  int done_cnt = 0;
  bit mon_en = 1'b1;

  typedef struct {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
    int         ones;
  } vec_t;
  vec_t vecs[3];

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever @(posedge clk) cnt++;

  // Pulse-width monitor: every falling edge of led_dout consumes one expected width.
  initial begin
    int run, last_rise, w;
    bit prev;
    run = 0; last_rise = -1000; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev = 1'b0; run = 0; last_rise = -1000;
      end else begin
        if (led_dout === 1'b1) begin
          if (!prev) begin
            if (cnt - last_rise < 200) check("bit_period", cnt - last_rise, TB);
            last_rise = cnt;
          end
          run++;
        end else if (prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", run, 0);
          end else begin
            w = exp_q.pop_front();
            check("bit_high_width", run, w);
            if (run == 40) ones++;
          end
          run = 0;
        end
        prev = (led_dout === 1'b1);
      end
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  task automatic push_frame(input logic [23:0] word);
    for (int p = 0; p < NL; p++)
      for (int i = 23; i >= 0; i--)
        exp_q.push_back(word[i] ? 40 : 20);
  endtask

  task automatic start_frame(input logic [7:0] g, input logic [7:0] r,
                             input logic [7:0] b, output int k);
    @(negedge clk); #1;
    color_g = g; color_r = r; color_b = b;
    start = 1'b1;
    k = cnt + 1;
    ones = 0;
    push_frame({g, r, b});
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("first_bit_high", led_dout, 1);
    #1 start = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cnt < t) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int k, output int d);
    int n;
    n = 0; d = -1;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 7000) begin
      @(negedge clk);
      n++;
    end
    if (frame_done !== 1'b1) begin
      check("done_timeout", 0, 1);
    end else begin
      d = cnt;
      check("done_offset", cnt - k, FRAME_OFF);
      check("busy_at_done", busy, 1);
    end
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", frame_done, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d, d0;
    vecs[0] = '{8'h80, 8'h00, 8'h01, 4};
    vecs[1] = '{8'hA5, 8'h3C, 8'h0F, 24};
    vecs[2] = '{8'h01, 8'hFE, 8'h7F, 30};

    // Reset then idle
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {led_dout, busy, frame_done}, 0);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outputs", {led_dout, busy, frame_done}, 0);
    end

    // Table-driven single frames
    for (int i = 0; i < 3; i++) begin
      start_frame(vecs[i].g, vecs[i].r, vecs[i].b, k);
      wait_done(k, d);
      check("ones_count", ones, vecs[i].ones);
      check("queue_empty", exp_q.size(), 0);
    end

    // Colour change mid-frame is ignored until the next start
    start_frame(8'hFF, 8'hFF, 8'hFF, k);
    wait_until(k + 100);
    color_g = 8'h00; color_r = 8'h00; color_b = 8'h00;
    wait_done(k, d);
    check("all_ones_frame", ones, 48);
    start_frame(color_g, color_r, color_b, k);
    wait_done(k, d);
    check("all_zero_frame", ones, 0);
    check("queue_empty_cc", exp_q.size(), 0);

    // start while busy is ignored, in SEND and in LATCH
    d0 = done_cnt;
    start_frame(8'hA5, 8'h3C, 8'h0F, k);
    wait_until(k + 500);
    start = 1'b1; @(negedge clk); #1 start = 1'b0;
    wait_until(k + 4000);
    start = 1'b1; @(negedge clk); #1 start = 1'b0;
    wait_done(k, d);
    repeat (100) @(negedge clk);
    check("no_queued_frame_busy", busy, 0);
    check("single_frame_done", done_cnt - d0, 1);
    check("ones_busy_start", ones, 24);

    // start held high: back-to-back frames with a 1-cycle IDLE gap
    @(negedge clk); #1;
    color_g = 8'h80; color_r = 8'h00; color_b = 8'h01;
    start = 1'b1;
    k = cnt + 1;
    push_frame(24'h800001);
    push_frame(24'h800001);
    wait_done(k, d);
    @(negedge clk);
    check("b2b_gap_cycle", cnt - d, 2);
    check("b2b_restart_led", led_dout, 1);
    check("b2b_restart_busy", busy, 1);
    #1 start = 1'b0;
    wait_done(d + 2, d0);
    check("b2b_done_spacing", d0 - d, FRAME_OFF + 2);
    check("queue_empty_b2b", exp_q.size(), 0);

    // Asynchronous reset at bit 10 of pixel 0 aborts the frame
    d0 = done_cnt;
    start_frame(8'h80, 8'h00, 8'h01, k);
    wait_until(k + 10 * TB + 5);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("abort_led_low", led_dout, 0);
    check("abort_busy_low", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    repeat (50) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_line_idle", {led_dout, busy}, 0);
    start_frame(8'h80, 8'h00, 8'h01, k);
    wait_done(k, d);
    check("post_abort_ones", ones, 4);
    check("queue_empty_abort", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_driver.md
Name: ws2812_frame_driver

Overview:
- Downstream consumer of the 8-bit colour PIO output ports.
- Latches one G/R/B colour triple on a start request.
- Serialises that triple to NUM_LEDS chained WS2812-class LEDs over a single-wire NRZ output, then holds the line low for the latch/reset interval.
- Sits between the Avalon colour/control PIOs and the board LED data pin.

Parameters:
- NUM_LEDS, 60, number of pixels per frame; every pixel gets the same latched colour; range 1..1023.
- T0H, 20, clk cycles high for a '0' bit (0.4 us at 50 MHz).
- T1H, 40, clk cycles high for a '1' bit (0.8 us at 50 MHz).
- TBIT, 63, total clk cycles per bit period; must exceed T1H.
- TRESET, 3000, clk cycles of low after the last bit (60 us at 50 MHz).

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- color_g, input, 8, green byte from the colour PIO out_port.
- color_r, input, 8, red byte from the colour PIO out_port.
- color_b, input, 8, blue byte from the colour PIO out_port.
- start, input, 1, frame request; sampled every cycle.
- busy, output, 1, high from the cycle after start is accepted until frame_done.
- frame_done, output, 1, one-cycle pulse when the TRESET interval ends.
- led_dout, output, 1, serial data to the first LED.

Behaviour:
- Reset: async on reset_n low.
  - State returns to IDLE.
  - led_dout=0, busy=0, frame_done=0.
  - All counters and the shift register are cleared.
  - Reset mid-frame aborts immediately; the line stays low. There is no resume.
- States: IDLE, SEND, LATCH, DONE.
- IDLE:
  - When start=1 at edge k:
    - word <= {color_g, color_r, color_b}.
    - bit_cnt<=0, pix_cnt<=0, cyc_cnt<=0.
    - Go to SEND.
  - busy=1 and led_dout=1 from cycle k+1.
- SEND: bit timing.
  - led_dout=1 while cyc_cnt < (word[23] ? T1H : T0H), else 0.
  - cyc_cnt counts 0..TBIT-1.
  - At cyc_cnt==TBIT-1: cyc_cnt wraps to 0 and the shift register rotates left by 1 (bit 23 goes to bit 0), so the word is reused for the next pixel. bit_cnt increments.
  - At bit_cnt==23 with end of bit: bit_cnt wraps to 0 and pix_cnt increments.
  - If pix_cnt==NUM_LEDS-1 at that point, go to LATCH with cyc_cnt=0.
  - Bit order is MSB first, G then R then B.
- LATCH:
  - led_dout=0 for exactly TRESET cycles, counted 0..TRESET-1.
  - Then go to DONE.
- DONE:
  - One cycle with frame_done=1 and busy still 1.
  - Next cycle: IDLE, busy=0.
- Frame length: exactly NUM_LEDS*24*TBIT cycles of SEND plus TRESET LATCH cycles plus 1 DONE cycle.
- Colour inputs are ignored after the latch; changes mid-frame take effect only on the next start.
- start while busy is ignored and not queued. start held high re-triggers on the first IDLE cycle, giving back-to-back frames with a 1-cycle IDLE gap.
- Counter widths:
  - cyc_cnt wide enough for max(TBIT, TRESET).
  - pix_cnt clog2(NUM_LEDS+1).
  - bit_cnt 5 bits.
- No combinational path from inputs to outputs. All outputs are registered.

Decomposition:
- Shared package (ws2812_pkg) holds:
  - The state encoding enum {IDLE, SEND, LATCH, DONE}.
  - Default timing constants for 50 MHz.
  - The constant WORD_W=24.
- One natural sub-module: ws2812_bit_timer.
  - Inputs: clk, reset_n, bit_start, bit_val.
  - Outputs: dout, bit_end.
  - Owns cyc_cnt and the T0H/T1H/TBIT comparison.
- The top level owns the FSM, the shift register, pix_cnt and the TRESET counter.

Test Plan:
1. Reset then idle: reset_n=0 for 3 cycles, released, start=0 for 100 cycles -> led_dout=0, busy=0, frame_done=0 throughout.
2. Single frame, NUM_LEDS=2, G=0x80 R=0x00 B=0x01, start pulsed for 1 cycle -> bit0 high 40 cycles; bits 1..22 high 20 cycles each; bit 23 high 40 cycles; pattern repeats for pixel 2; then 3000 low cycles; frame_done pulses at cycle 1+2*24*63+3000; busy falls on the next cycle.
3. Colour change mid-frame: start with G=R=B=0xFF, then set all to 0x00 after 100 cycles -> every bit of the frame is a '1' (40-cycle high); the next frame sends all '0' (20-cycle high).
4. start re-asserted during SEND and during LATCH -> ignored; frame length unchanged; exactly one frame_done.
5. start held high continuously -> consecutive frames separated by exactly 1 IDLE cycle; led_dout rises the cycle after each DONE+IDLE.
6. reset_n asserted at bit 10 of pixel 0 -> led_dout=0 and busy=0 immediately (asynchronous); no frame_done; a new start after release sends a full, correct frame.
